// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, lane helpers.
// No logic of its own; functions are purely combinational.
// Not applicable (no handshake).
package load_store_unit_pkg;

  // RISC-V funct3 encodings; loads and stores share the B/H/W codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_RMW_READ = 2'd2,
    ST_WRITE    = 2'd3
  } state_t;

  // Bit offset of a byte lane inside a 32-bit word
  function automatic logic [4:0] lane_shift(input logic [1:0] lane);
    return {lane, 3'b000};
  endfunction

  // A request is rejected when its funct3 is illegal for its direction or its address is misaligned
  function automatic logic req_bad(input logic is_store, input logic [2:0] f3, input logic [1:0] lane);
    logic illegal;
    logic misaligned;
    if (is_store) illegal = (f3 > F3_W);
    else          illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    misaligned = ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
// Purely combinational, zero latency.
// No handshake; the owning FSM decides when the results are used.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] read_word,
  input  logic [31:0] merge_word,
  input  logic [31:0] store_data,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;

  assign shifted = read_word >> lane_shift(lane);
  assign byte_sh = lane_shift(lane);
  assign half_sh = lane_shift({lane[1], 1'b0});

  // Pick the addressed lane and sign- or zero-extend it
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = shifted;
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

  // Overlay the new byte/half onto the previously read word; full words pass straight through
  always_comb begin
    store_word = store_data;
    case (funct3)
      F3_B: store_word = (merge_word & ~(32'h0000_00FF << byte_sh)) |
                         ({24'h0, store_data[7:0]} << byte_sh);
      F3_H: store_word = (merge_word & ~(32'h0000_FFFF << half_sh)) |
                         ({16'h0, store_data[15:0]} << half_sh);
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store master for a word-wide memory with combinational read and posedge write.
// Latency accept->respValid: error 1, load 2, SW 2, SB/SH 3 (read-modify-write).
// reqReady only in IDLE; requests offered while busy are ignored and must be held.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int MEM_WORD_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqIsStore,
  input  logic [2:0]            reqFunct3,
  input  logic [ADDR_WIDTH-1:0] reqAddress,
  input  logic [31:0]           reqStoreData,
  output logic                  respValid,
  output logic                  respError,
  output logic [31:0]           respLoadData,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memWriteEnable,
  output logic [31:0]           memWriteData,
  input  logic [31:0]           memReadData
);

  state_t                state;
  state_t                state_nxt;
  logic                  accept;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [2:0]            f3_q;
  logic [1:0]            lane_q;
  logic [31:0]           data_q;
  logic [31:0]           merge_buf;
  logic [31:0]           load_data;
  logic [31:0]           store_word;

  assign accept  = reqValid & reqReady;
  assign req_err = req_bad(reqIsStore, reqFunct3, reqAddress[1:0]);
  assign mem_addr_nxt = (MEM_WORD_ADDR != 0) ? (reqAddress >> 2)
                                             : {reqAddress[ADDR_WIDTH-1:2], 2'b00};

  load_store_unit_align u_align (
    .read_word  (memReadData),
    .merge_word (merge_buf),
    .store_data (data_q),
    .lane       (lane_q),
    .funct3     (f3_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // State register; async reset returns to IDLE so a pending write is abandoned at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: rejected requests never leave IDLE; sub-word stores read before writing
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && !req_err) begin
          if (!reqIsStore)            state_nxt = ST_LOAD;
          else if (reqFunct3 == F3_W) state_nxt = ST_WRITE;
          else                        state_nxt = ST_RMW_READ;
        end
      end
      ST_LOAD:     state_nxt = ST_IDLE;
      ST_RMW_READ: state_nxt = ST_WRITE;
      ST_WRITE:    state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: write strobe and data exist only during WRITE
  always_comb begin
    reqReady       = (state == ST_IDLE);
    memWriteEnable = (state == ST_WRITE);
    memWriteData   = (state == ST_WRITE) ? store_word : 32'h0;
  end

  // Latch the accepted request; memAddress moves only for requests that touch memory
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f3_q       <= '0;
      lane_q     <= '0;
      data_q     <= '0;
      memAddress <= '0;
    end else if (accept) begin
      f3_q   <= reqFunct3;
      lane_q <= reqAddress[1:0];
      data_q <= reqStoreData;
      if (!req_err) memAddress <= mem_addr_nxt;
    end
  end

  // Capture the old word during RMW_READ so WRITE can merge into it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       merge_buf <= '0;
    else if (state == ST_RMW_READ)  merge_buf <= memReadData;
  end

  // Completion pulse and load result; the result holds until the next completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      respValid    <= 1'b0;
      respError    <= 1'b0;
      respLoadData <= '0;
    end else begin
      respValid <= 1'b0;
      respError <= 1'b0;
      if (accept && req_err) begin
        respValid    <= 1'b1;
        respError    <= 1'b1;
        respLoadData <= '0;
      end else if (state == ST_LOAD) begin
        respValid    <= 1'b1;
        respLoadData <= load_data;
      end else if (state == ST_WRITE) begin
        respValid    <= 1'b1;
        respLoadData <= '0;
      end
    end
  end

endmodule
